// File: rtl/uart_iomem_pkg.sv
// Shared constants, state encoding and bus request type for the UART-to-iomem bridge.
package uart_iomem_pkg;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;

  localparam int CMD_BYTES_ADDR = 4;
  localparam int CMD_BYTES_DATA = 4;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, BUS, RESP} state_e;

  typedef struct packed {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
  } bus_req_t;

endpackage

// File: rtl/uart_iomem_resp_ser.sv
// Response serializer: loads a word plus byte count (1 or 4) and emits it MSB first
// on a valid/ready byte stream; done pulses on the handshake of the last byte.
module uart_iomem_resp_ser (
  input  logic        clk,
  input  logic        resetn,
  input  logic        load,
  input  logic        four,
  input  logic [31:0] word,
  input  logic        out_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  output logic        done
);

  logic [31:0] sh_q;
  logic [2:0]  rem_q;
  logic        hs;

  // Shifting zeros in behind the data leaves out_data at 0 once the word is drained.
  assign out_valid = (rem_q != 3'd0);
  assign out_data  = sh_q[31:24];
  assign hs        = out_valid && out_ready;
  assign done      = hs && (rem_q == 3'd1);

  always_ff @(posedge clk) begin
    if (!resetn) begin
      sh_q  <= '0;
      rem_q <= '0;
    end else if (load) begin
      sh_q  <= word;
      rem_q <= four ? 3'd4 : 3'd1;
    end else if (hs) begin
      sh_q  <= {sh_q[23:0], 8'h00};
      rem_q <= rem_q - 3'd1;
    end
  end

endmodule

// File: rtl/uart_iomem_bridge.sv
// Command-byte-stream to iomem initiator bridge with a byte response stream.
// Define UART_IOMEM_TIMEOUT_EN to abort stalled bus cycles after TIMEOUT_CYCLES.
module uart_iomem_bridge
  import uart_iomem_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [7:0]  out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  if (TIMEOUT_CYCLES < 2) begin : g_tmo_chk
    $error("TIMEOUT_CYCLES must be at least 2");
  end

  state_e      state_q, state_d;
  logic [1:0]  cnt_q;
  logic        is_write_q;
  bus_req_t    req_q;
  logic        iomem_valid_q;
  logic        in_hs, bus_done, bus_tmo;
  logic        ser_load, ser_four, ser_done;
  logic [31:0] ser_word;

  assign in_ready    = resetn && (state_q inside {IDLE, ADDR, DATA});
  assign in_hs       = in_valid && in_ready;
  assign busy        = (state_q != IDLE);
  assign iomem_valid = iomem_valid_q;
  assign iomem_addr  = req_q.addr;
  assign iomem_wdata = req_q.wdata;
  assign iomem_wstrb = req_q.wstrb;
  assign bus_done    = (state_q == BUS) && iomem_valid_q && iomem_ready;

`ifdef UART_IOMEM_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] tmo_q;

  always_ff @(posedge clk) begin
    if (!resetn || state_q != BUS) tmo_q <= '0;
    else if (iomem_valid_q)        tmo_q <= tmo_q + TW'(1);
  end

  // A ready in the final cycle takes precedence over the abort.
  assign bus_tmo = (state_q == BUS) && iomem_valid_q && !iomem_ready &&
                   (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`else
  assign bus_tmo = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: if (in_hs && (in_data == CMD_WRITE || in_data == CMD_READ)) state_d = ADDR;
      ADDR: if (in_hs && cnt_q == 2'(CMD_BYTES_ADDR - 1)) state_d = is_write_q ? DATA : BUS;
      DATA: if (in_hs && cnt_q == 2'(CMD_BYTES_DATA - 1)) state_d = BUS;
      BUS:  if (bus_done || bus_tmo) state_d = RESP;
      RESP: if (ser_done) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Read data goes straight into the serializer, which is its only holding register.
  assign ser_load = bus_done || bus_tmo;
  assign ser_four = bus_done && !is_write_q;
  assign ser_word = bus_tmo    ? {RSP_ERR, 24'h0} :
                    is_write_q ? {RSP_ACK, 24'h0} : iomem_rdata;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q       <= IDLE;
      cnt_q         <= '0;
      is_write_q    <= 1'b0;
      req_q         <= '0;
      iomem_valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      if (state_q == IDLE && in_hs) is_write_q <= (in_data == CMD_WRITE);
      if (in_hs && state_q inside {ADDR, DATA}) cnt_q <= cnt_q + 2'd1;
      if (in_hs && state_q == ADDR) req_q.addr  <= {req_q.addr[23:0], in_data};
      if (in_hs && state_q == DATA) req_q.wdata <= {req_q.wdata[23:0], in_data};
      if (state_d == BUS && state_q != BUS) begin
        iomem_valid_q <= 1'b1;
        req_q.wstrb   <= is_write_q ? 4'hF : 4'h0;
      end
      if (ser_load) begin
        iomem_valid_q <= 1'b0;
        req_q.wstrb   <= 4'h0;
      end
    end
  end

  uart_iomem_resp_ser u_ser (
    .clk       (clk),
    .resetn    (resetn),
    .load      (ser_load),
    .four      (ser_four),
    .word      (ser_word),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_valid (out_valid),
    .done      (ser_done)
  );

endmodule

// File: doc/uart_iomem_bridge.md
Name: uart_iomem_bridge

Overview:
Byte-stream-to-bus initiator that lets a host drive the iomem peripheral bus over the USB UART byte pipeline.
- Consumes command bytes from the usb_uart output stream.
- Issues single 32-bit read/write transactions as iomem initiator to the existing GPIO/template responders.
- Returns a response byte stream to the usb_uart input stream.
- Sits in the 12 MHz domain beside the peripheral bus decode, acting as a debug master in place of or alongside the CPU.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles iomem_valid is held waiting for iomem_ready before abort (only with timeout feature).

Ports:
clk  in  1  system clock, all logic on posedge.
resetn  in  1  synchronous active-low reset, sampled on posedge clk.
in_data  in  8  command byte stream data.
in_valid  in  1  command byte valid.
in_ready  out  1  bridge accepts a command byte.
out_data  out  8  response byte.
out_valid  out  1  response byte valid.
out_ready  in  1  sink accepts response byte.
iomem_valid  out  1  bus request.
iomem_ready  in  1  responder completion, single-cycle pulse.
iomem_wstrb  out  4  byte write strobes; 0 = read.
iomem_addr  out  32  bus address.
iomem_wdata  out  32  write data.
iomem_rdata  in  32  read data, valid while iomem_ready = 1.
busy  out  1  high in any state other than IDLE.

Behaviour:
- Byte transfer on either stream occurs on a posedge where valid && ready are both high.
- Reset (resetn = 0 at posedge):
  - State goes to IDLE, counters clear.
  - in_ready = 0, out_valid = 0, out_data = 0, iomem_valid = 0, iomem_wstrb = 0, iomem_addr = 0, iomem_wdata = 0, busy = 0.
  - Reset asserted mid-command or mid-bus-transaction aborts without a response.
- Command format, all multi-byte fields MSB first:
  - Write: 0x57 'W', addr[4], data[4].
  - Read: 0x52 'R', addr[4].
- States:
  - IDLE: in_ready = 1.
    - 0x57 → ADDR with is_write = 1.
    - 0x52 → ADDR with is_write = 0.
    - Any other byte is consumed and dropped; stay in IDLE; no response.
  - ADDR: in_ready = 1. Shift each byte into addr (addr <= {addr[23:0], byte}); 2-bit counter.
    - After 4th byte: DATA if write, else BUS.
  - DATA: in_ready = 1. Same shifting into wdata; after 4th byte → BUS.
  - BUS: in_ready = 0.
    - iomem_valid is asserted registered on entry and held with stable addr, wdata and wstrb (4'hF for write, 4'h0 for read).
    - On a posedge with iomem_ready = 1: iomem_valid <= 0 at that edge, and rdata is latched if read → RESP.
    - iomem_valid is high in the same cycle as iomem_ready, so a responder gating on !iomem_ready does not re-fire.
  - RESP:
    - Write sends 1 byte: 0x4B 'K'.
    - Read sends 4 bytes: rdata[31:24], [23:16], [15:8], [7:0].
    - out_valid stays high and out_data stays stable until out_ready; next byte is presented on the following cycle.
    - After the last byte is accepted → IDLE.
- Latency:
  - iomem_valid rises 1 cycle after the final command byte handshake.
  - out_valid rises 1 cycle after iomem_ready.
- in_ready is never high outside IDLE/ADDR/DATA; no command byte is buffered during BUS/RESP.
- An iomem_ready pulse arriving while iomem_valid = 0 is ignored.

Optional Feature:
UART_IOMEM_TIMEOUT_EN
- Defined:
  - Cycle counter runs in BUS, width $clog2(TIMEOUT_CYCLES+1).
  - If TIMEOUT_CYCLES cycles elapse with no iomem_ready: iomem_valid <= 0, respond single byte 0x45 'E' (for both read and write), return to IDLE.
  - iomem_ready in the same cycle as the timeout wins (normal completion).
  - A later ready is ignored.
- Undefined: BUS waits indefinitely; counter logic is absent.

Decomposition:
- Package uart_iomem_pkg:
  - CMD_WRITE = 8'h57, CMD_READ = 8'h52, RSP_ACK = 8'h4B, RSP_ERR = 8'h45.
  - State enum {IDLE, ADDR, DATA, BUS, RESP}.
  - CMD_BYTES_ADDR = 4, CMD_BYTES_DATA = 4.
- One sub-module: uart_iomem_resp_ser.
  - Loads a 32-bit word plus byte count (1 or 4).
  - Drives out_data/out_valid MSB first under out_ready backpressure.
  - Signals done.

Test Plan:
- Write: bytes 57 03 00 00 00 00 00 00 03, responder ready after 1 cycle → iomem_addr = 0x03000000, wdata = 0x00000003, wstrb = F, valid high exactly 2 cycles; output 4B.
- Read: bytes 52 03 00 00 00, responder rdata = 0x12345678 with ready after 3 cycles → wstrb = 0; output 12 34 56 78.
- Garbage: byte 41 then a valid read → 41 dropped with no output; read completes normally.
- Backpressure: out_ready low 10 cycles during read response → out_data holds 12 for all 10 cycles; no byte lost or duplicated.
- Timeout (UART_IOMEM_TIMEOUT_EN, TIMEOUT_CYCLES = 16): read of 0x05000000 with no responder → iomem_valid drops after 16 cycles; output 45; a following read succeeds.
- Reset mid-ADDR: resetn low 1 cycle after 2 address bytes → all outputs zero; next full write command executes correctly.
